// File: rtl/sram_arbiter_pkg.sv
// Bus encodings and arbiter-wide types shared by the SRAM arbiter, its slots and the bench.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef SRAM_SIZE
`define SRAM_SIZE 524288
`endif
`ifndef SRAM_ARB_IDLE
`define SRAM_ARB_IDLE 2'd0
`endif
`ifndef SRAM_ARB_ISSUE
`define SRAM_ARB_ISSUE 2'd1
`endif
`ifndef SRAM_ARB_WAIT
`define SRAM_ARB_WAIT 2'd2
`endif
`ifndef SRAM_ARB_NPORT
`define SRAM_ARB_NPORT 2
`endif

package sram_arbiter_pkg;
  localparam int BUS_W     = `BUS_WIDTH;
  localparam int ACC_W     = `BUS_ACC_WIDTH;
  localparam int NPORT     = `SRAM_ARB_NPORT;
  localparam int SRAM_SIZE = `SRAM_SIZE;

  localparam logic [ACC_W-1:0] ACC_1B = `BUS_ACC_1B;
  localparam logic [ACC_W-1:0] ACC_2B = `BUS_ACC_2B;
  localparam logic [ACC_W-1:0] ACC_4B = `BUS_ACC_4B;

  typedef enum logic [1:0] {
    ARB_IDLE  = `SRAM_ARB_IDLE,
    ARB_ISSUE = `SRAM_ARB_ISSUE,
    ARB_WAIT  = `SRAM_ARB_WAIT
  } arb_state_e;
endpackage

// File: rtl/sram_arb_slot.sv
// One outstanding request per port; a new request in the clearing cycle wins over the clear.
module sram_arb_slot
  import sram_arbiter_pkg::*;
#(
  parameter int AW = 19
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_i,
  input  logic             clr_i,
  input  logic             w_rb_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [ACC_W-1:0] acc_i,
  input  logic [BUS_W-1:0] wdata_i,
  output logic             valid_o,
  output logic             w_rb_o,
  output logic [AW-1:0]    addr_o,
  output logic [ACC_W-1:0] acc_o,
  output logic [BUS_W-1:0] wdata_o
);
  logic             valid_q, valid_d, take;
  logic             w_rb_q;
  logic [AW-1:0]    addr_q;
  logic [ACC_W-1:0] acc_q;
  logic [BUS_W-1:0] wdata_q;

  assign take    = req_i && (!valid_q || clr_i);
  assign valid_d = take || (valid_q && !clr_i);

  always_ff @(posedge clk) begin
    if (!rstn) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // Payload is only meaningful while valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      w_rb_q  <= w_rb_i;
      addr_q  <= addr_i;
      acc_q   <= acc_i;
      wdata_q <= wdata_i;
    end
  end

  assign valid_o = valid_q;
  assign w_rb_o  = w_rb_q;
  assign addr_o  = addr_q;
  assign acc_o   = acc_q;
  assign wdata_o = wdata_q;

  a_no_overrun: assert property (@(posedge clk) disable iff (!rstn)
    !(req_i && valid_q && !clr_i));
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port between fetch (p0) and data (p1), with watchdog.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW      = $clog2(SRAM_SIZE),
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             p0_req,
  input  logic             p0_w_rb,
  input  logic [AW-1:0]    p0_addr,
  input  logic [ACC_W-1:0] p0_acc,
  input  logic [BUS_W-1:0] p0_wdata,
  output logic [BUS_W-1:0] p0_rdata,
  output logic             p0_resp,
  output logic             p0_fault,
  input  logic             p1_req,
  input  logic             p1_w_rb,
  input  logic [AW-1:0]    p1_addr,
  input  logic [ACC_W-1:0] p1_acc,
  input  logic [BUS_W-1:0] p1_wdata,
  output logic [BUS_W-1:0] p1_rdata,
  output logic             p1_resp,
  output logic             p1_fault,
  output logic             dn_req,
  output logic             dn_w_rb,
  output logic [AW-1:0]    dn_addr,
  output logic [ACC_W-1:0] dn_acc,
  output logic [BUS_W-1:0] dn_wdata,
  input  logic [BUS_W-1:0] dn_rdata,
  input  logic             dn_resp,
  input  logic             dn_fault
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [NPORT-1:0] s_req, s_clr, s_vld, s_w_rb_in, s_w_rb;
  logic [AW-1:0]    s_addr_in  [NPORT];
  logic [AW-1:0]    s_addr     [NPORT];
  logic [ACC_W-1:0] s_acc_in   [NPORT];
  logic [ACC_W-1:0] s_acc      [NPORT];
  logic [BUS_W-1:0] s_wdata_in [NPORT];
  logic [BUS_W-1:0] s_wdata    [NPORT];

  arb_state_e  state_q;
  logic        grant_q, grant_d, last_q;
  logic [CW-1:0] cnt_q;
  logic        timeout_hit, done_resp, done_fault;

  assign s_req         = {p1_req, p0_req};
  assign s_w_rb_in     = {p1_w_rb, p0_w_rb};
  assign s_addr_in[0]  = p0_addr;
  assign s_addr_in[1]  = p1_addr;
  assign s_acc_in[0]   = p0_acc;
  assign s_acc_in[1]   = p1_acc;
  assign s_wdata_in[0] = p0_wdata;
  assign s_wdata_in[1] = p1_wdata;

  for (genvar i = 0; i < NPORT; i++) begin : g_slot
    sram_arb_slot #(.AW(AW)) u_slot (
      .clk     (clk),
      .rstn    (rstn),
      .req_i   (s_req[i]),
      .clr_i   (s_clr[i]),
      .w_rb_i  (s_w_rb_in[i]),
      .addr_i  (s_addr_in[i]),
      .acc_i   (s_acc_in[i]),
      .wdata_i (s_wdata_in[i]),
      .valid_o (s_vld[i]),
      .w_rb_o  (s_w_rb[i]),
      .addr_o  (s_addr[i]),
      .acc_o   (s_acc[i]),
      .wdata_o (s_wdata[i])
    );
  end

  // On a tie the port not served last wins; otherwise the only valid port.
  assign grant_d     = (s_vld == 2'b11) ? ~last_q : ~s_vld[0];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Completion pulses are combinational on the downstream inputs and masked during reset.
  assign done_resp  = rstn && (state_q == ARB_WAIT) && dn_resp;
  assign done_fault = rstn && (((state_q == ARB_ISSUE) && dn_fault) ||
                               ((state_q == ARB_WAIT) && !dn_resp && timeout_hit));
  assign s_clr[0]   = (done_resp || done_fault) && !grant_q;
  assign s_clr[1]   = (done_resp || done_fault) && grant_q;

  assign p0_resp  = done_resp && !grant_q;
  assign p1_resp  = done_resp && grant_q;
  assign p0_fault = done_fault && !grant_q;
  assign p1_fault = done_fault && grant_q;
  assign p0_rdata = dn_rdata;
  assign p1_rdata = dn_rdata;

  assign dn_req   = rstn && (state_q == ARB_ISSUE);
  assign dn_w_rb  = s_w_rb[grant_q];
  assign dn_addr  = s_addr[grant_q];
  assign dn_acc   = s_acc[grant_q];
  assign dn_wdata = s_wdata[grant_q];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|s_vld) begin
            grant_q <= grant_d;
            state_q <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (dn_fault) begin
            last_q  <= grant_q;
            state_q <= ARB_IDLE;
          end else begin
            cnt_q   <= '0;
            state_q <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (dn_resp || timeout_hit) begin
            last_q  <= grant_q;
            state_q <= ARB_IDLE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scoreboard bench for sram_arbiter; a TIMEOUT=0 twin shares the stimulus.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW = 19;

  typedef struct {
    bit               port;
    logic             w;
    logic [AW-1:0]    addr;
    logic [ACC_W-1:0] acc;
    logic [BUS_W-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rstn;
  logic p0_req, p0_w_rb, p1_req, p1_w_rb;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [ACC_W-1:0] p0_acc, p1_acc;
  logic [BUS_W-1:0] p0_wdata, p1_wdata;
  logic [BUS_W-1:0] dn_rdata;
  logic dn_resp, dn_fault;

  logic [BUS_W-1:0] p0_rdata, p1_rdata, dn_wdata;
  logic p0_resp, p0_fault, p1_resp, p1_fault, dn_req, dn_w_rb;
  logic [AW-1:0] dn_addr;
  logic [ACC_W-1:0] dn_acc;

  logic [BUS_W-1:0] nt_p0_rdata, nt_p1_rdata, nt_dn_wdata;
  logic nt_p0_resp, nt_p0_fault, nt_p1_resp, nt_p1_fault, nt_dn_req, nt_dn_w_rb;
  logic [AW-1:0] nt_dn_addr;
  logic [ACC_W-1:0] nt_dn_acc;

  int checks = 0;
  int errors = 0;
  bit last_m = 1'b1;
  txn_t sb[$];

  always #5 clk = ~clk;

  sram_arbiter #(.AW(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_w_rb(p0_w_rb), .p0_addr(p0_addr), .p0_acc(p0_acc), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_resp(p0_resp), .p0_fault(p0_fault),
    .p1_req(p1_req), .p1_w_rb(p1_w_rb), .p1_addr(p1_addr), .p1_acc(p1_acc), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_resp(p1_resp), .p1_fault(p1_fault),
    .dn_req(dn_req), .dn_w_rb(dn_w_rb), .dn_addr(dn_addr), .dn_acc(dn_acc), .dn_wdata(dn_wdata),
    .dn_rdata(dn_rdata), .dn_resp(dn_resp), .dn_fault(dn_fault)
  );

  sram_arbiter #(.AW(AW), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_w_rb(p0_w_rb), .p0_addr(p0_addr), .p0_acc(p0_acc), .p0_wdata(p0_wdata),
    .p0_rdata(nt_p0_rdata), .p0_resp(nt_p0_resp), .p0_fault(nt_p0_fault),
    .p1_req(p1_req), .p1_w_rb(p1_w_rb), .p1_addr(p1_addr), .p1_acc(p1_acc), .p1_wdata(p1_wdata),
    .p1_rdata(nt_p1_rdata), .p1_resp(nt_p1_resp), .p1_fault(nt_p1_fault),
    .dn_req(nt_dn_req), .dn_w_rb(nt_dn_w_rb), .dn_addr(nt_dn_addr), .dn_acc(nt_dn_acc),
    .dn_wdata(nt_dn_wdata),
    .dn_rdata(dn_rdata), .dn_resp(dn_resp), .dn_fault(dn_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit port, input logic w, input logic [AW-1:0] a,
                       input logic [ACC_W-1:0] c, input logic [BUS_W-1:0] d, input bit push);
    txn_t t;
    t = '{port, w, a, c, d};
    if (port) begin
      p1_req = 1'b1; p1_w_rb = w; p1_addr = a; p1_acc = c; p1_wdata = d;
    end else begin
      p0_req = 1'b1; p0_w_rb = w; p0_addr = a; p0_acc = c; p0_wdata = d;
    end
    if (push) sb.push_back(t);
    tick();
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic tie(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    txn_t t0, t1;
    t0 = '{1'b0, 1'b0, a0, ACC_4B, 32'h0};
    t1 = '{1'b1, 1'b0, a1, ACC_4B, 32'h0};
    p0_req = 1'b1; p0_w_rb = 1'b0; p0_addr = a0; p0_acc = ACC_4B;
    p1_req = 1'b1; p1_w_rb = 1'b0; p1_addr = a1; p1_acc = ACC_4B;
    if (last_m) begin
      sb.push_back(t0); sb.push_back(t1);
    end else begin
      sb.push_back(t1); sb.push_back(t0);
    end
    tick();
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    while (dn_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("dn_req_seen", 64'(dn_req), 64'd1);
  endtask

  task automatic pop_check(output txn_t t);
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) t = sb.pop_front();
    else t = '{1'b0, 1'b0, '0, '0, '0};
    chk("dn_fields", 64'({dn_w_rb, dn_addr, dn_acc}), 64'({t.w, t.addr, t.acc}));
    if (t.w) chk("dn_wdata", 64'(dn_wdata), 64'(t.wdata));
  endtask

  task automatic serve(input int lat, input logic [BUS_W-1:0] rd, input bit rereq,
                       input logic [AW-1:0] ra, output int n);
    txn_t t, nx;
    wait_issue(n);
    pop_check(t);
    repeat (lat) tick();
    dn_resp = 1'b1;
    dn_rdata = rd;
    if (rereq) begin
      p0_req = 1'b1; p0_w_rb = 1'b0; p0_addr = ra; p0_acc = ACC_4B;
      nx = '{1'b0, 1'b0, ra, ACC_4B, 32'h0};
      sb.push_back(nx);
    end
    #1;
    chk("resp_route", 64'({p0_resp, p1_resp, p0_fault, p1_fault}),
        t.port ? 64'b0100 : 64'b1000);
    if (!t.w) chk("rdata", 64'(t.port ? p1_rdata : p0_rdata), 64'(rd));
    tick();
    dn_resp = 1'b0;
    p0_req = 1'b0;
    last_m = t.port;
  endtask

  initial begin
    int n;
    bit nt_fault_seen;
    txn_t t;
    rstn = 1'b0;
    p0_req = 0; p0_w_rb = 0; p0_addr = '0; p0_acc = '0; p0_wdata = '0;
    p1_req = 0; p1_w_rb = 0; p1_addr = '0; p1_acc = '0; p1_wdata = '0;
    dn_rdata = '0; dn_resp = 0; dn_fault = 0;
    tick();
    tick();
    chk("reset_outputs", 64'({dn_req, p0_resp, p1_resp, p0_fault, p1_fault}), 64'd0);
    chk("reset_state", 64'(dut.state_q), 64'(ARB_IDLE));
    chk("reset_slots", 64'(dut.s_vld), 64'd0);
    rstn = 1'b1;
    tick();

    // Single read with issue latency and a 4-cycle downstream response.
    drive(1'b0, 1'b0, 19'h100, ACC_4B, 32'h0, 1'b1);
    chk("issue_not_early", 64'(dn_req), 64'd0);
    serve(4, 32'hDEADBEEF, 1'b0, '0, n);
    chk("issue_lat", 64'(n), 64'd1);

    // Round-robin ties starting from reset; odd rounds first serve p0 alone so p1 wins the tie.
    rstn = 1'b0; tick(); rstn = 1'b1; last_m = 1'b1; tick();
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 1) begin
        drive(1'b0, 1'b0, 19'h080 + 19'(r * 4), ACC_4B, 32'h0, 1'b1);
        serve(2, 32'hC000_0000 + 32'(r), 1'b0, '0, n);
      end
      tie(19'h200 + 19'(r * 4), 19'h300 + 19'(r * 4));
      serve(3, 32'hA000_0000 + 32'(r), 1'b0, '0, n);
      serve(2, 32'hB000_0000 + 32'(r), 1'b0, '0, n);
      chk("second_issue_lat", 64'(n <= 2), 64'd1);
    end

    // Fault forwarded from the ISSUE cycle.
    drive(1'b1, 1'b1, 19'h002, ACC_4B, 32'h12345678, 1'b1);
    wait_issue(n);
    pop_check(t);
    dn_fault = 1'b1;
    #1;
    chk("fault_route", 64'({p0_resp, p1_resp, p0_fault, p1_fault}), 64'b0001);
    tick();
    dn_fault = 1'b0;
    last_m = 1'b1;
    chk("fault_idle", 64'(dut.state_q), 64'(ARB_IDLE));
    chk("fault_slot", 64'(dut.s_vld), 64'd0);
    dn_resp = 1'b1;
    #1;
    chk("fault_no_resp", 64'({p0_resp, p1_resp}), 64'd0);
    tick();
    dn_resp = 1'b0;

    // Back-to-back: p0 re-requests in its response cycle.
    drive(1'b0, 1'b0, 19'h100, ACC_4B, 32'h0, 1'b1);
    serve(2, 32'h11110000, 1'b1, 19'h104, n);
    serve(2, 32'h22220000, 1'b0, '0, n);
    chk("b2b_issue_lat", 64'(n <= 2), 64'd1);

    // Watchdog: fault in the 15th WAIT cycle; the TIMEOUT=0 twin keeps waiting.
    drive(1'b0, 1'b0, 19'h180, ACC_4B, 32'h0, 1'b1);
    wait_issue(n);
    pop_check(t);
    tick();
    for (int k = 0; k < 15; k++) begin
      chk("wd_fault", 64'(p0_fault), 64'(k == 14));
      if (k < 14) tick();
    end
    chk("wd_nt_nofault", 64'(nt_p0_fault), 64'd0);
    tick();
    chk("wd_idle", 64'(dut.state_q), 64'(ARB_IDLE));
    nt_fault_seen = 1'b0;
    for (int k = 0; k < 86; k++) begin
      nt_fault_seen |= nt_p0_fault;
      tick();
    end
    chk("nt_no_fault_100", 64'(nt_fault_seen), 64'd0);
    chk("nt_still_wait", 64'(dut_nt.state_q), 64'(ARB_WAIT));
    dn_resp = 1'b1;
    dn_rdata = 32'h0BADF00D;
    #1;
    chk("late_resp_ignored", 64'(p0_resp), 64'd0);
    chk("nt_late_resp", 64'(nt_p0_resp), 64'd1);
    tick();
    dn_resp = 1'b0;
    last_m = 1'b0;

    // Reset while p1 waits and p0 is pending.
    drive(1'b1, 1'b0, 19'h040, ACC_2B, 32'h0, 1'b1);
    wait_issue(n);
    pop_check(t);
    tick();
    drive(1'b0, 1'b1, 19'h044, ACC_1B, 32'h55, 1'b0);
    chk("rst_pending", 64'(dut.s_vld), 64'b11);
    rstn = 1'b0;
    dn_resp = 1'b1;
    #1;
    chk("in_reset_outputs", 64'({dn_req, p0_resp, p1_resp, p0_fault, p1_fault}), 64'd0);
    tick();
    rstn = 1'b1;
    #1;
    chk("post_reset_outputs", 64'({dn_req, p0_resp, p1_resp, p0_fault, p1_fault}), 64'd0);
    chk("post_reset_slots", 64'({dut.s_vld, dut_nt.s_vld}), 64'd0);
    chk("post_reset_nt_resp", 64'({nt_p0_resp, nt_p1_resp}), 64'd0);
    tick();
    dn_resp = 1'b0;
    chk("post_reset_no_issue", 64'(dn_req), 64'd0);
    tick();
    chk("post_reset_no_issue2", 64'({dn_req, nt_dn_req}), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
